// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port 32-bit RAM between the programming port, the CPU
// data bus and the CPU instruction bus. A grant is decided every cycle from
// the current requests plus registered state. Read data returns exactly one
// cycle later and is steered to whichever port issued the read.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   prog_en/addr/wstrb/wdata      programming port; locks out the CPU while high
//   prog_rdata                    RAM read data for the previous prog address
//   i_cmd_valid/ready/addr        instruction fetch command (byte address)
//   i_rsp_valid/data              instruction fetch response
//   d_cmd_valid/ready/wr/addr/
//   d_cmd_wstrb/wdata             data command (byte address, RAM space only)
//   d_rsp_valid/data              data read response (never for writes)
//   ram_addr/en/wstrb/wdata       RAM command (word address)
//   ram_rdata                     RAM registered read data
module ram_port_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int MAX_DBUS_RUN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prog_en,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [3:0]        prog_wstrb,
   input  logic [31:0]       prog_wdata,
   output logic [31:0]       prog_rdata,
   input  logic              i_cmd_valid,
   output logic              i_cmd_ready,
   input  logic [31:0]       i_cmd_addr,
   output logic              i_rsp_valid,
   output logic [31:0]       i_rsp_data,
   input  logic              d_cmd_valid,
   output logic              d_cmd_ready,
   input  logic              d_cmd_wr,
   input  logic [31:0]       d_cmd_addr,
   input  logic [3:0]        d_cmd_wstrb,
   input  logic [31:0]       d_cmd_wdata,
   output logic              d_rsp_valid,
   output logic [31:0]       d_rsp_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_en,
   output logic [3:0]        ram_wstrb,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic {MODE_RUN, MODE_PROG} mode_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

   localparam logic [3:0] RUN_LIMIT = 4'(MAX_DBUS_RUN);

   mode_t       mode_reg;
   owner_t      owner_reg, owner_next;
   logic [3:0]  run_reg, run_next;
   logic        grant_p, grant_d, grant_i;
   logic [3:0]  d_wstrb_eff;

   // Only the word-address field of the CPU byte addresses reaches the RAM.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_cmd_addr[31:ADDR_W+2], i_cmd_addr[1:0],
                               d_cmd_addr[31:ADDR_W+2], d_cmd_addr[1:0]};

   // Reads carry no byte enables into the RAM.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wstrb
         assign d_wstrb_eff[gi] = d_cmd_wr & d_cmd_wstrb[gi];
      end
   endgenerate

   // Grant: prog beats everything; dBus beats iBus unless iBus has already
   // watched RUN_LIMIT consecutive dBus grants go by.
   always_comb begin
      grant_p = !rst && prog_en;
      grant_d = !rst && !prog_en && d_cmd_valid &&
                !(i_cmd_valid && (run_reg == RUN_LIMIT));
      grant_i = !rst && !prog_en && i_cmd_valid && !grant_d;
   end

   always_comb begin
      ram_en    = grant_p | grant_d | grant_i;
      ram_addr  = i_cmd_addr[ADDR_W+1:2];
      ram_wstrb = 4'b0000;
      ram_wdata = d_cmd_wdata;
      if (grant_p) begin
         ram_addr  = prog_addr;
         ram_wstrb = prog_wstrb;
         ram_wdata = prog_wdata;
      end else if (grant_d) begin
         ram_addr  = d_cmd_addr[ADDR_W+1:2];
         ram_wstrb = d_wstrb_eff;
      end
   end

   assign i_cmd_ready = grant_i;
   assign d_cmd_ready = grant_d;

   always_comb begin
      owner_next = OWN_NONE;
      if (grant_i)
         owner_next = OWN_I;
      else if (grant_d && !d_cmd_wr)
         owner_next = OWN_D;
   end

   // The run counter holds its value while prog blocks a waiting fetch.
   always_comb begin
      run_next = run_reg;
      if (grant_d && i_cmd_valid)
         run_next = run_reg + 4'd1;
      else if (grant_i || !i_cmd_valid)
         run_next = 4'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg  <= MODE_RUN;
         owner_reg <= OWN_NONE;
         run_reg   <= 4'd0;
      end else begin
         if (mode_reg == MODE_RUN) begin
            if (prog_en)
               mode_reg <= MODE_PROG;
         end else begin
            if (!prog_en)
               mode_reg <= MODE_RUN;
         end
         owner_reg <= owner_next;
         run_reg   <= run_next;
      end
   end

   // A response due while rst is high is dropped outright.
   assign i_rsp_valid = !rst && (mode_reg == MODE_RUN) && (owner_reg == OWN_I);
   assign d_rsp_valid = !rst && (mode_reg == MODE_RUN) && (owner_reg == OWN_D);
   assign i_rsp_data  = ram_rdata;
   assign d_rsp_data  = ram_rdata;
   assign prog_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios followed by random traffic.
// A predictor works out each cycle's grant from the arbitration rules and
// queues expected read data from a reference memory; a separate monitor
// pops and compares whenever a response is due or presented.
module tb_ram_port_arbiter;
   localparam int ADDR_W  = 14;
   localparam int MAX_RUN = 4;
   localparam int WORDS   = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              prog_en;
   logic [ADDR_W-1:0] prog_addr;
   logic [3:0]        prog_wstrb;
   logic [31:0]       prog_wdata;
   logic [31:0]       prog_rdata;
   logic              i_cmd_valid, i_cmd_ready, i_rsp_valid;
   logic [31:0]       i_cmd_addr, i_rsp_data;
   logic              d_cmd_valid, d_cmd_ready, d_cmd_wr, d_rsp_valid;
   logic [31:0]       d_cmd_addr, d_cmd_wdata, d_rsp_data;
   logic [3:0]        d_cmd_wstrb;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_en;
   logic [3:0]        ram_wstrb;
   logic [31:0]       ram_wdata, ram_rdata;

   ram_port_arbiter #(.ADDR_W(ADDR_W), .MAX_DBUS_RUN(MAX_RUN)) dut (
      .clk(clk), .rst(rst),
      .prog_en(prog_en), .prog_addr(prog_addr), .prog_wstrb(prog_wstrb),
      .prog_wdata(prog_wdata), .prog_rdata(prog_rdata),
      .i_cmd_valid(i_cmd_valid), .i_cmd_ready(i_cmd_ready), .i_cmd_addr(i_cmd_addr),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
      .d_cmd_valid(d_cmd_valid), .d_cmd_ready(d_cmd_ready), .d_cmd_wr(d_cmd_wr),
      .d_cmd_addr(d_cmd_addr), .d_cmd_wstrb(d_cmd_wstrb), .d_cmd_wdata(d_cmd_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .ram_addr(ram_addr), .ram_en(ram_en), .ram_wstrb(ram_wstrb),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // RAM array with registered, read-first output.
   logic [31:0] ram_mem [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (ram_en) begin
         ram_rdata <= ram_mem[ram_addr];
         ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_wdata, ram_wstrb);
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%08h required=%08h", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        sb [3][$];          // 0 = iBus, 1 = dBus, 2 = prog
   logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
   int          run_m = 0;          // consecutive dBus wins while a fetch waits

   task automatic push(input int p, input logic [31:0] data);
      exp_t e;
      e.due  = cyc + 1;
      e.data = data;
      sb[p].push_back(e);
   endtask

   task automatic predict();
      logic              ep, ed, ei;
      logic [ADDR_W-1:0] dw, iw;
      ep = 1'b0; ed = 1'b0; ei = 1'b0;
      dw = d_cmd_addr[ADDR_W+1:2];
      iw = i_cmd_addr[ADDR_W+1:2];
      if (rst) begin
         run_m = 0;
      end else if (prog_en) begin
         ep = 1'b1;
         if (!i_cmd_valid) run_m = 0;
      end else if (d_cmd_valid && !(i_cmd_valid && run_m == MAX_RUN)) begin
         ed = 1'b1;
         run_m = i_cmd_valid ? run_m + 1 : 0;
      end else if (i_cmd_valid) begin
         ei = 1'b1;
         run_m = 0;
      end else begin
         run_m = 0;
      end
      chk("i_cmd_ready", 32'(i_cmd_ready), 32'(ei));
      chk("d_cmd_ready", 32'(d_cmd_ready), 32'(ed));
      chk("ram_en", 32'(ram_en), 32'(ep | ed | ei));
      if (ep) begin
         chk("prog_ram_addr", 32'(ram_addr), 32'(prog_addr));
         chk("prog_ram_wstrb", 32'(ram_wstrb), 32'(prog_wstrb));
         if (prog_wstrb != 4'b0000) begin
            chk("prog_ram_wdata", ram_wdata, prog_wdata);
            ref_mem[prog_addr] = merge(ref_mem[prog_addr], prog_wdata, prog_wstrb);
         end else begin
            push(2, ref_mem[prog_addr]);
         end
      end
      if (ed) begin
         chk("d_ram_addr", 32'(ram_addr), 32'(dw));
         chk("d_ram_wstrb", 32'(ram_wstrb), d_cmd_wr ? 32'(d_cmd_wstrb) : 32'd0);
         if (d_cmd_wr) begin
            chk("d_ram_wdata", ram_wdata, d_cmd_wdata);
            ref_mem[dw] = merge(ref_mem[dw], d_cmd_wdata, d_cmd_wstrb);
         end else begin
            push(1, ref_mem[dw]);
         end
      end
      if (ei) begin
         chk("i_ram_addr", 32'(ram_addr), 32'(iw));
         chk("i_ram_wstrb", 32'(ram_wstrb), 32'd0);
         push(0, ref_mem[iw]);
      end
   endtask

   initial forever begin
      @(negedge clk);
      predict();
   end

   task automatic monitor_port(input int p, input string nm, input logic v,
                               input logic [31:0] data, input logic has_valid);
      logic due;
      exp_t e;
      due = (sb[p].size() > 0) && (sb[p][0].due == cyc);
      if (rst) begin
         if (has_valid) chk({nm, "_rsp_valid_in_rst"}, 32'(v), 32'd0);
         if (due) e = sb[p].pop_front();
      end else begin
         if (has_valid) chk({nm, "_rsp_valid"}, 32'(v), 32'(due));
         if (due) begin
            e = sb[p].pop_front();
            chk({nm, "_rsp_data"}, data, e.data);
            $display("cyc=%0d rsp %s data=%08h expected=%08h", cyc, nm, data, e.data);
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      monitor_port(0, "i", i_rsp_valid, i_rsp_data, 1'b1);
      monitor_port(1, "d", d_rsp_valid, d_rsp_data, 1'b1);
      monitor_port(2, "prog", 1'b0, prog_rdata, 1'b0);
   end

   // ---------------- stimulus ----------------
   task automatic cyc_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_i(input logic v, input logic [31:0] a);
      i_cmd_valid = v;
      i_cmd_addr  = a;
   endtask

   task automatic set_d(input logic v, input logic wr, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] w);
      d_cmd_valid = v;
      d_cmd_wr    = wr;
      d_cmd_addr  = a;
      d_cmd_wstrb = s;
      d_cmd_wdata = w;
   endtask

   task automatic idle();
      set_i(1'b0, 32'd0);
      set_d(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      prog_en    = 1'b0;
      prog_wstrb = 4'd0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, WORDS - 1));
      return a;
   endfunction

   function automatic logic [31:0] init_val(input int w);
      case (w)
         16'h10:  return 32'hDEADBEEF;
         16'h20:  return 32'h12345678;
         5:       return 32'h00000000;
         default: return (32'(w) * 32'h9E3779B9) ^ 32'h5A5A0000;
      endcase
   endfunction

   initial begin
      logic d_acc, i_acc;
      rst = 1'b1;
      prog_addr = '0;
      prog_wdata = '0;
      idle();
      cyc_step();
      cyc_step();
      rst = 1'b0;

      // Load words 0..WORDS-1 through the programming port.
      prog_en = 1'b1;
      for (int w = 0; w < WORDS; w++) begin
         prog_addr  = ADDR_W'(w);
         prog_wstrb = 4'hF;
         prog_wdata = init_val(w);
         cyc_step();
      end
      idle();
      cyc_step();

      // Reset with both requesters active, then first read after release.
      rst = 1'b1;
      set_i(1'b1, 32'h40);
      set_d(1'b1, 1'b0, 32'h80, 4'd0, 32'd0);
      cyc_step();
      cyc_step();
      rst = 1'b0;
      set_i(1'b0, 32'd0);
      set_d(1'b1, 1'b0, 32'h40, 4'd0, 32'd0);
      @(negedge clk);
      chk("release_d_ready", 32'(d_cmd_ready), 32'd1);
      cyc_step();
      idle();
      @(negedge clk);
      chk("release_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
      chk("release_d_rsp_data", d_rsp_data, 32'hDEADBEEF);
      cyc_step();

      // Contention: dBus first, fetch the cycle after.
      set_i(1'b1, 32'h40);
      set_d(1'b1, 1'b0, 32'h80, 4'd0, 32'd0);
      @(negedge clk);
      chk("cont_d_ready", 32'(d_cmd_ready), 32'd1);
      chk("cont_i_ready", 32'(i_cmd_ready), 32'd0);
      cyc_step();
      set_d(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      @(negedge clk);
      chk("cont_d_rsp_data", d_rsp_data, 32'h12345678);
      chk("cont_i_ready_2", 32'(i_cmd_ready), 32'd1);
      cyc_step();
      set_i(1'b0, 32'd0);
      @(negedge clk);
      chk("cont_i_rsp_valid", 32'(i_rsp_valid), 32'd1);
      chk("cont_i_rsp_data", i_rsp_data, 32'hDEADBEEF);
      cyc_step();

      // Starvation: both held high -> D,D,D,D,I repeating.
      set_i(1'b1, 32'h08);
      set_d(1'b1, 1'b0, 32'h04, 4'd0, 32'd0);
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk("starve_d_ready", 32'(d_cmd_ready), 32'((k % 5) != 4));
         chk("starve_i_ready", 32'(i_cmd_ready), 32'((k % 5) == 4));
         cyc_step();
      end
      idle();
      cyc_step();

      // Byte write into word 5, then read it back.
      set_d(1'b1, 1'b1, 32'h16, 4'b0100, 32'h00AB0000);
      @(negedge clk);
      chk("bw_d_ready", 32'(d_cmd_ready), 32'd1);
      cyc_step();
      set_d(1'b1, 1'b0, 32'h14, 4'd0, 32'd0);
      @(negedge clk);
      chk("bw_no_rsp_for_write", 32'(d_rsp_valid), 32'd0);
      cyc_step();
      idle();
      @(negedge clk);
      chk("bw_rsp_valid", 32'(d_rsp_valid), 32'd1);
      chk("bw_rsp_data", d_rsp_data, 32'h00AB0000);
      cyc_step();

      // Programming with CPU requests pending.
      set_i(1'b1, 32'h20);
      set_d(1'b1, 1'b0, 32'h24, 4'd0, 32'd0);
      prog_en = 1'b1; prog_addr = ADDR_W'(3); prog_wstrb = 4'hF; prog_wdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("prog_i_locked", 32'(i_cmd_ready), 32'd0);
      chk("prog_d_locked", 32'(d_cmd_ready), 32'd0);
      cyc_step();
      prog_wstrb = 4'd0;
      cyc_step();
      prog_en = 1'b0;
      set_d(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      set_i(1'b1, 32'h0C);
      @(negedge clk);
      chk("prog_rdata", prog_rdata, 32'hCAFEF00D);
      chk("post_prog_i_ready", 32'(i_cmd_ready), 32'd1);
      cyc_step();
      set_i(1'b0, 32'd0);
      @(negedge clk);
      chk("post_prog_i_rsp", i_rsp_data, 32'hCAFEF00D);
      cyc_step();

      // Read accepted, prog_en rises the next cycle: response still delivered.
      set_d(1'b1, 1'b0, 32'h14, 4'd0, 32'd0);
      cyc_step();
      set_d(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      prog_en = 1'b1; prog_addr = ADDR_W'(7); prog_wstrb = 4'd0;
      @(negedge clk);
      chk("progrise_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
      chk("progrise_d_rsp_data", d_rsp_data, 32'h00AB0000);
      cyc_step();
      idle();
      cyc_step();

      // Reset in the cycle after a read accept suppresses the response.
      set_d(1'b1, 1'b0, 32'h80, 4'd0, 32'd0);
      cyc_step();
      idle();
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_rsp_n1", 32'(d_rsp_valid), 32'd0);
      cyc_step();
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_rsp_n2", 32'(d_rsp_valid), 32'd0);
      cyc_step();

      // Random traffic; requesters hold their command until accepted.
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         d_acc = d_cmd_valid && d_cmd_ready;
         i_acc = i_cmd_valid && i_cmd_ready;
         cyc_step();
         rst = ($urandom_range(0, 99) == 0);
         if (prog_en) prog_en = ($urandom_range(0, 7) != 0);
         else         prog_en = ($urandom_range(0, 39) == 0);
         prog_addr  = ADDR_W'($urandom_range(0, WORDS - 1));
         prog_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
         prog_wdata = $urandom;
         if (!d_cmd_valid || d_acc) begin
            if ($urandom_range(0, 2) != 0)
               set_d(1'b1, 1'($urandom), rand_addr(), 4'($urandom), $urandom);
            else
               d_cmd_valid = 1'b0;
         end
         if (!i_cmd_valid || i_acc) begin
            if ($urandom_range(0, 3) != 0)
               set_i(1'b1, rand_addr());
            else
               i_cmd_valid = 1'b0;
         end
      end
      rst = 1'b0;
      idle();
      cyc_step();
      cyc_step();
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
